fetch_queue: RTL and testbench

Instruction queue between the fetch stage and decode. It holds up to DEPTH fetched instruction/PC pairs so that icache hits keep arriving while decode stalls. Fetch pushes with a valid/ready handshake, decode pops with a valid/ready handshake, and a redirect flush discards every buffered entry. Replaces the direct fetch-to-decode latch path and isolates icache timing from decode stalls.

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fetch_queue_ctrl.sv | 64 ++++++
 rtl/fetch_queue.sv | 79 +++++++
 tb/tb_fetch_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared LC-3b types for the fetch queue: instruction/PC word, storage entry, default depth.
package fetch_queue_pkg;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        lc3b_word ir;
        lc3b_word pc;
    } lc3b_fq_entry;

    localparam int unsigned FQ_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fetch_queue_ctrl.sv
// Pointer/occupancy control for fetch_queue; FETCH_QUEUE_BYPASS_EN suppresses the write
// when an empty queue hands the input straight to a ready decode stage.
module fetch_queue_ctrl
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq_valid,
    input  logic          deq_ready,
    input  logic          flush,
    output logic          wr_en,
    output logic          rd_en,
    output logic          enq_ready,
    output logic          empty,
    output logic          full,
    output logic [AW-1:0] rd_ptr,
    output logic [AW-1:0] wr_ptr,
    output logic [CW-1:0] count
);

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign enq_ready = !full;

    always_comb begin
        wr_en = enq_valid && enq_ready && !flush;
        rd_en = !empty && deq_ready && !flush;
`ifdef FETCH_QUEUE_BYPASS_EN
        // Entry is consumed combinationally on the bypass path, so it never lands in storage.
        if (empty && deq_ready) begin
            wr_en = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: storage array plus head/bypass output mux.
// Optional zero-latency pass-through when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq_valid,
    input  logic [15:0]   enq_ir,
    input  logic [15:0]   enq_pc,
    output logic          enq_ready,
    output logic          deq_valid,
    output logic [15:0]   deq_ir,
    output logic [15:0]   deq_pc,
    input  logic          deq_ready,
    input  logic          flush,
    output logic [CW-1:0] count
);

    logic          wr_en;
    logic          rd_en;
    logic          empty;
    logic          full;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    lc3b_fq_entry  mem [DEPTH];
    lc3b_fq_entry  head;

    fetch_queue_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .enq_valid (enq_valid),
        .deq_ready (deq_ready),
        .flush     (flush),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .enq_ready (enq_ready),
        .empty     (empty),
        .full      (full),
        .rd_ptr    (rd_ptr),
        .wr_ptr    (wr_ptr),
        .count     (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= '{ir: enq_ir, pc: enq_pc};
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        deq_valid = !empty && !flush;
        deq_ir    = head.ir;
        deq_pc    = head.pc;
`ifdef FETCH_QUEUE_BYPASS_EN
        // Reset gates the bypass so outputs stay quiet while rst is high.
        if (empty && !flush && !rst) begin
            deq_valid = enq_valid;
            deq_ir    = enq_ir;
            deq_pc    = enq_pc;
        end
`endif
    end

    a_no_write_when_full: assert property (@(posedge clk) disable iff (rst) full |-> !wr_en);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model; works with
// and without FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam bit BYP =
`ifdef FETCH_QUEUE_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid;
    logic [15:0] enq_ir;
    logic [15:0] enq_pc;
    logic        enq_ready;
    logic        deq_valid;
    logic [15:0] deq_ir;
    logic [15:0] deq_pc;
    logic        deq_ready;
    logic        flush;
    logic [2:0]  count;

    ent_t        mq[$];
    logic        e_dv;
    logic        e_rdy;
    logic [2:0]  e_cnt;
    logic [15:0] e_ir;
    logic [15:0] e_pc;
    int          checks = 0;
    int          errors = 0;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enq_valid (enq_valid),
        .enq_ir    (enq_ir),
        .enq_pc    (enq_pc),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_ir    (deq_ir),
        .deq_pc    (deq_pc),
        .deq_ready (deq_ready),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic string obs_str();
        return $sformatf("got dv=%b cnt=%0d rdy=%b ir=%h pc=%h, want dv=%b cnt=%0d rdy=%b ir=%h pc=%h",
                         deq_valid, count, enq_ready, deq_ir, deq_pc, e_dv, e_cnt, e_rdy, e_ir, e_pc);
    endfunction

    // Drive one cycle's inputs after the falling edge and derive expectations from the model.
    task automatic drive(input logic ev, input logic [15:0] ir, input logic [15:0] pc,
                         input logic dr, input logic fl);
        @(negedge clk);
        enq_valid = ev;
        enq_ir    = ir;
        enq_pc    = pc;
        deq_ready = dr;
        flush     = fl;
        e_cnt = 3'(mq.size());
        e_rdy = (mq.size() != DEPTH);
        e_ir  = 16'hxxxx;
        e_pc  = 16'hxxxx;
        if (mq.size() != 0) begin
            e_dv = !fl;
            e_ir = mq[0].ir;
            e_pc = mq[0].pc;
        end else if (BYP && !fl) begin
            e_dv = ev;
            e_ir = ir;
            e_pc = pc;
        end else begin
            e_dv = 1'b0;
        end
        #1;
    endtask

    // Apply the effect of the upcoming rising edge to the model.
    task automatic commit();
        bit rd;
        bit wr;
        if (flush) begin
            mq.delete();
        end else if (!(BYP && mq.size() == 0 && enq_valid && deq_ready)) begin
            rd = (mq.size() != 0) && deq_ready;
            wr = enq_valid && (mq.size() != DEPTH);
            if (rd) void'(mq.pop_front());
            if (wr) mq.push_back('{ir: enq_ir, pc: enq_pc});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && mq.size() != 0; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            commit();
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 16'hBEEF, 16'h1234, 1'b0, 1'b0);
        commit();
        drive(1'b1, 16'hCAFE, 16'h1236, 1'b0, 1'b0);
        commit();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({deq_valid, count, enq_ready, deq_ir, deq_pc} !== {1'b0, 3'd0, 1'b1, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL reset: got dv=%b cnt=%0d rdy=%b ir=%h pc=%h, want dv=0 cnt=0 rdy=1 ir=0000 pc=0000",
                     deq_valid, count, enq_ready, deq_ir, deq_pc);
        end
        mq.delete();
        @(negedge clk);
        enq_valid = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 6; i++) begin
            drive(i < 5, 16'h1001 + 16'(i), 16'h3002 + 16'(2 * i), 1'b0, 1'b0);
            checks++;
            if ({deq_valid, count, enq_ready} !== {e_dv, e_cnt, e_rdy} ||
                (e_dv && {deq_ir, deq_pc} !== {e_ir, e_pc})) begin
                errors++;
                $display("FAIL fill[%0d]: %s", i, obs_str());
            end
            commit();
        end
    endtask

    task automatic test_drain_wrap();
        for (int i = 0; i < 11; i++) begin
            if (i < 5) drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            else       drive(1'b1, 16'h1100 + 16'(i), 16'h3100 + 16'(2 * i), 1'b1, 1'b0);
            checks++;
            if ({deq_valid, count, enq_ready} !== {e_dv, e_cnt, e_rdy} ||
                (e_dv && {deq_ir, deq_pc} !== {e_ir, e_pc})) begin
                errors++;
                $display("FAIL drain_wrap[%0d]: %s", i, obs_str());
            end
            commit();
        end
        drain();
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0, 1:    drive(1'b1, 16'h1A00 + 16'(i), 16'h3A00 + 16'(2 * i), 1'b0, 1'b0);
                2:       drive(1'b1, 16'h2000, 16'h3A10, 1'b1, 1'b0);
                default: drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            endcase
            checks++;
            if ({deq_valid, count, enq_ready} !== {e_dv, e_cnt, e_rdy} ||
                (e_dv && {deq_ir, deq_pc} !== {e_ir, e_pc})) begin
                errors++;
                $display("FAIL simultaneous[%0d]: %s", i, obs_str());
            end
            commit();
        end
        drain();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0, 1, 2: drive(1'b1, 16'h1B00 + 16'(i), 16'h3B00 + 16'(2 * i), 1'b0, 1'b0);
                3:       drive(1'b1, 16'h2000, 16'h4000, 1'b0, 1'b1);
                5:       drive(1'b1, 16'h2222, 16'h4444, 1'b0, 1'b0);
                default: drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            endcase
            checks++;
            if ({deq_valid, count, enq_ready} !== {e_dv, e_cnt, e_rdy} ||
                (e_dv && {deq_ir, deq_pc} !== {e_ir, e_pc})) begin
                errors++;
                $display("FAIL flush[%0d]: %s", i, obs_str());
            end
            commit();
        end
        drain();
    endtask

    task automatic test_empty_passthrough();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       drive(1'b1, 16'h5A5A, 16'h6000, 1'b1, 1'b0);
                2:       drive(1'b1, 16'h5A5A, 16'h6002, 1'b0, 1'b0);
                default: drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            endcase
            checks++;
            if ({deq_valid, count, enq_ready} !== {e_dv, e_cnt, e_rdy} ||
                (e_dv && {deq_ir, deq_pc} !== {e_ir, e_pc})) begin
                errors++;
                $display("FAIL passthrough[%0d]: %s", i, obs_str());
            end
            commit();
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
            checks++;
            if ({deq_valid, count, enq_ready} !== {e_dv, e_cnt, e_rdy} ||
                (e_dv && {deq_ir, deq_pc} !== {e_ir, e_pc})) begin
                errors++;
                $display("FAIL random[%0d]: %s", i, obs_str());
            end
            commit();
        end
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        enq_valid = 1'b0;
        enq_ir    = 16'h0;
        enq_pc    = 16'h0;
        deq_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_fill();
        test_drain_wrap();
        test_simultaneous();
        test_flush();
        test_empty_passthrough();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
